rv32_multicycle_core: RTL



---
 rtl/rv32_multicycle_core.sv | 329 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32_multicycle_core.sv
// rv32_multicycle_core: multicycle RV32I core on a single shared memory port.
//   Every instruction walks FETCH -> WAIT_INST -> EXECUTE. Loads continue
//   through WAIT_DATA, and stores continue through STORE -> WAIT_WRITE.
//   Any illegal, misaligned or ECALL/EBREAK instruction parks the core in HALT.
//   Only reset leaves HALT.
// Parameters: RESET_ADDR (reset pc), ADDR_WIDTH (driven address bits, 8..32),
//   NUM_REGS (32 = RV32I, 16 = RV32E).
// Optional: define RV32_CORE_COUNTERS_EN to add cycle/instret counters that
//   are readable with CSRRS rd,csr,x0. Without it, every SYSTEM opcode halts.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   mem_addr_o           word-aligned byte address, truncated to ADDR_WIDTH
//   mem_rstrb_o          one-cycle read strobe
//   mem_rdata_i          read data; valid once mem_rbusy_i is low after the strobe
//   mem_rbusy_i          read in progress
//   mem_wmask_o          byte enables, nonzero for one cycle per store
//   mem_wdata_o          store data, byte/half replicated across lanes
//   mem_wbusy_i          write in progress
//   halted_o             core stopped
module rv32_multicycle_core #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_rstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rbusy_i,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_wbusy_i,
    output logic        halted_o
);
    localparam int unsigned RIDX_W     = $clog2(NUM_REGS);
    localparam logic [63:0] AMASK_FULL = (64'd1 << ADDR_WIDTH) - 64'd1;
    localparam logic [31:0] ADDR_MASK  = AMASK_FULL[31:0] & 32'hFFFF_FFFC;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FETCH, WAIT_INST, EXECUTE, WAIT_DATA, STORE, WAIT_WRITE, HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q, instr_q, rs1_q, rs2_q, addr_q, wdata_q;
    logic        rstrb_q, halted_q;
    logic [3:0]  wmask_q;
    logic [1:0]  ea_lo_q;
    logic [31:0] regs_q [NUM_REGS];
`ifdef RV32_CORE_COUNTERS_EN
    logic [63:0] cycle_q, instret_q;
    logic        retire;
`endif

    // Decode fields
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rd_idx, rs1_idx, rs2_idx;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode  = instr_q[6:0];
    assign rd_idx  = instr_q[11:7];
    assign f3      = instr_q[14:12];
    assign rs1_idx = instr_q[19:15];
    assign rs2_idx = instr_q[24:20];
    assign f7      = instr_q[31:25];
    assign imm_i   = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s   = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b   = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_u   = {instr_q[31:12], 12'b0};
    assign imm_j   = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

    logic        illegal, use_rd, use_rs1, use_rs2, bad_reg, is_load, is_store;
    logic        misaligned, taken, redirect, halt_now, rd_we;
    logic [31:0] op_b, alu, csr_val, mem_ea, next_pc, rd_val, st_data, ld_word, ld_val;
    logic [4:0]  shamt;
    logic [3:0]  st_mask;

    // Legality and register usage per format
    always_comb begin
        illegal = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        csr_val = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: use_rd = 1'b1;
            OPC_JALR: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                illegal = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                illegal = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_LOAD: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                illegal = (f3 > 3'd2);
            end
            OPC_OPIMM: begin
                use_rd = 1'b1; use_rs1 = 1'b1;
                if (f3 == 3'd1) illegal = (f7 != 7'h00);
                else if (f3 == 3'd5) illegal = (f7 != 7'h00) && (f7 != 7'h20);
            end
            OPC_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                illegal = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OPC_FENCE: illegal = (f3 != 3'd0);
`ifdef RV32_CORE_COUNTERS_EN
            OPC_SYSTEM: begin
                // Only counter reads via CSRRS rd,csr,x0; ECALL/EBREAK land here too
                if (f3 == 3'd2 && rs1_idx == 5'd0) begin
                    use_rd = 1'b1;
                    case (instr_q[31:20])
                        12'hC00: csr_val = cycle_q[31:0];
                        12'hC80: csr_val = cycle_q[63:32];
                        12'hC02: csr_val = instret_q[31:0];
                        12'hC82: csr_val = instret_q[63:32];
                        default: illegal = 1'b1;
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
`else
            OPC_SYSTEM: illegal = 1'b1;
`endif
            default: illegal = 1'b1;
        endcase
    end

    assign bad_reg = (use_rd  && (32'(rd_idx)  >= NUM_REGS)) ||
                     (use_rs1 && (32'(rs1_idx) >= NUM_REGS)) ||
                     (use_rs2 && (32'(rs2_idx) >= NUM_REGS));

    // ALU; SUB only for register-register ops
    always_comb begin
        op_b  = (opcode == OPC_OP) ? rs2_q : imm_i;
        shamt = op_b[4:0];
        case (f3)
            3'd0:    alu = (opcode == OPC_OP && f7[5]) ? rs1_q - op_b : rs1_q + op_b;
            3'd1:    alu = rs1_q << shamt;
            3'd2:    alu = {31'b0, $signed(rs1_q) < $signed(op_b)};
            3'd3:    alu = {31'b0, rs1_q < op_b};
            3'd4:    alu = rs1_q ^ op_b;
            3'd5:    alu = f7[5] ? 32'($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
            3'd6:    alu = rs1_q | op_b;
            default: alu = rs1_q & op_b;
        endcase
    end

    always_comb begin
        case (f3)
            3'd0:    taken = (rs1_q == rs2_q);
            3'd1:    taken = (rs1_q != rs2_q);
            3'd4:    taken = ($signed(rs1_q) < $signed(rs2_q));
            3'd5:    taken = ($signed(rs1_q) >= $signed(rs2_q));
            3'd6:    taken = (rs1_q < rs2_q);
            3'd7:    taken = (rs1_q >= rs2_q);
            default: taken = 1'b0;
        endcase
    end

    // Next pc, write-back value and memory side
    always_comb begin
        next_pc  = pc_q + 32'd4;
        redirect = 1'b0;
        rd_val   = '0;
        case (opcode)
            OPC_LUI:   rd_val = imm_u;
            OPC_AUIPC: rd_val = pc_q + imm_u;
            OPC_JAL: begin
                rd_val = pc_q + 32'd4; next_pc = pc_q + imm_j; redirect = 1'b1;
            end
            OPC_JALR: begin
                rd_val = pc_q + 32'd4; next_pc = (rs1_q + imm_i) & 32'hFFFF_FFFE; redirect = 1'b1;
            end
            OPC_BRANCH: if (taken) begin
                next_pc = pc_q + imm_b; redirect = 1'b1;
            end
            OPC_OP, OPC_OPIMM: rd_val = alu;
            OPC_SYSTEM:        rd_val = csr_val;
            default:           rd_val = '0;
        endcase
    end

    assign is_load    = (opcode == OPC_LOAD);
    assign is_store   = (opcode == OPC_STORE);
    assign mem_ea     = rs1_q + (is_store ? imm_s : imm_i);
    assign misaligned = (is_load || is_store) &&
                        (((f3[1:0] == 2'd1) && mem_ea[0]) || ((f3[1:0] == 2'd2) && (mem_ea[1:0] != 2'b00)));
    assign halt_now   = illegal || bad_reg || misaligned || (redirect && (next_pc[1:0] != 2'b00));
    assign rd_we      = use_rd && !is_load && (rd_idx != 5'd0);

    always_comb begin
        case (f3[1:0])
            2'd0:    st_data = {4{rs2_q[7:0]}};
            2'd1:    st_data = {2{rs2_q[15:0]}};
            default: st_data = rs2_q;
        endcase
        case (f3[1:0])
            2'd0:    st_mask = 4'b0001 << ea_lo_q;
            2'd1:    st_mask = ea_lo_q[1] ? 4'b1100 : 4'b0011;
            default: st_mask = 4'b1111;
        endcase
    end

    always_comb begin
        ld_word = mem_rdata_i >> {ea_lo_q, 3'b000};
        case (f3)
            3'd0:    ld_val = {{24{ld_word[7]}}, ld_word[7:0]};
            3'd1:    ld_val = {{16{ld_word[15]}}, ld_word[15:0]};
            3'd4:    ld_val = {24'b0, ld_word[7:0]};
            3'd5:    ld_val = {16'b0, ld_word[15:0]};
            default: ld_val = ld_word;
        endcase
    end

`ifdef RV32_CORE_COUNTERS_EN
    assign retire = (state_q == EXECUTE && !halt_now && !is_load && !is_store) ||
                    (state_q == WAIT_DATA && !rstrb_q && !mem_rbusy_i) ||
                    (state_q == WAIT_WRITE && wmask_q == 4'b0 && !mem_wbusy_i);
`endif

    // Strobes are registered, so the waiting states skip the cycle in which
    // their own strobe is still visible; memory responds only after it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= FETCH;
            pc_q     <= RESET_ADDR;
            instr_q  <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            addr_q   <= RESET_ADDR & ADDR_MASK;
            wdata_q  <= '0;
            rstrb_q  <= 1'b0;
            wmask_q  <= '0;
            ea_lo_q  <= '0;
            halted_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef RV32_CORE_COUNTERS_EN
            cycle_q   <= '0;
            instret_q <= '0;
`endif
        end else begin
            rstrb_q <= 1'b0;
            wmask_q <= '0;
`ifdef RV32_CORE_COUNTERS_EN
            if (state_q != HALT) cycle_q <= cycle_q + 64'd1;
            if (retire) instret_q <= instret_q + 64'd1;
`endif
            case (state_q)
                FETCH: begin
                    addr_q  <= pc_q & ADDR_MASK;
                    rstrb_q <= 1'b1;
                    state_q <= WAIT_INST;
                end
                WAIT_INST: if (!rstrb_q && !mem_rbusy_i) begin
                    instr_q <= mem_rdata_i;
                    rs1_q   <= regs_q[mem_rdata_i[15 +: RIDX_W]];
                    rs2_q   <= regs_q[mem_rdata_i[20 +: RIDX_W]];
                    state_q <= EXECUTE;
                end
                EXECUTE: begin
                    if (halt_now) begin
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else if (is_load) begin
                        addr_q  <= mem_ea & ADDR_MASK;
                        ea_lo_q <= mem_ea[1:0];
                        rstrb_q <= 1'b1;
                        state_q <= WAIT_DATA;
                    end else if (is_store) begin
                        addr_q  <= mem_ea & ADDR_MASK;
                        ea_lo_q <= mem_ea[1:0];
                        wdata_q <= st_data;
                        state_q <= STORE;
                    end else begin
                        if (rd_we) regs_q[rd_idx[RIDX_W-1:0]] <= rd_val;
                        pc_q    <= next_pc;
                        state_q <= FETCH;
                    end
                end
                WAIT_DATA: if (!rstrb_q && !mem_rbusy_i) begin
                    if (rd_idx != 5'd0) regs_q[rd_idx[RIDX_W-1:0]] <= ld_val;
                    pc_q    <= pc_q + 32'd4;
                    state_q <= FETCH;
                end
                STORE: begin
                    wmask_q <= st_mask;
                    state_q <= WAIT_WRITE;
                end
                WAIT_WRITE: if (wmask_q == 4'b0 && !mem_wbusy_i) begin
                    pc_q    <= pc_q + 32'd4;
                    state_q <= FETCH;
                end
                default: begin
                    halted_q <= 1'b1;
                    state_q  <= HALT;
                end
            endcase
        end
    end

    // Gated so that nothing strobes during a reset cycle
    assign mem_rstrb_o = rstrb_q && !rst_i;
    assign mem_wmask_o = rst_i ? 4'b0 : wmask_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign halted_o    = halted_q;

endmodule
